// File: rtl/if_id_queue.sv
// IF/ID decoupling FIFO of {instruction, npc}: one-cycle fall-through latency, no same-cycle bypass.
// Backpressure: in_ready = not full and out_valid = not empty, both decoded from registered count only.
module if_id_queue #(
  parameter int DATA_W = 32,
  parameter int NPC_W  = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instruction,
  input  logic [NPC_W-1:0]  in_npc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instruction,
  output logic [NPC_W-1:0]  out_npc,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] instruction;
    logic [NPC_W-1:0]  npc;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  entry_t           head;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pointers are exactly log2(DEPTH) wide, so increments wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Storage is deliberately left uncleared by reset and flush; count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= '{instruction: in_instruction, npc: in_npc};
  end

  assign head            = mem[rd_ptr];
  assign out_instruction = out_valid ? head.instruction : '0;
  assign out_npc         = out_valid ? head.npc : '0;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed + randomized bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;
  localparam int DATA_W = 32;
  localparam int NPC_W  = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instruction;
  logic [NPC_W-1:0]  in_npc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instruction;
  logic [NPC_W-1:0]  out_npc;
  logic [CNT_W-1:0]  count;

  if_id_queue #(.DATA_W(DATA_W), .NPC_W(NPC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_npc(in_npc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_npc(out_npc),
    .count(count)
  );

  typedef struct {
    logic [DATA_W-1:0] ins;
    logic [NPC_W-1:0]  npc;
  } pair_t;

  pair_t model_q[$];
  int    checks = 0;
  int    errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the queue.
  task automatic check_outputs(input string tag);
    logic [DATA_W-1:0] exp_ins;
    logic [NPC_W-1:0]  exp_npc;
    exp_ins = '0;
    exp_npc = '0;
    if (model_q.size() != 0) begin
      exp_ins = model_q[0].ins;
      exp_npc = model_q[0].npc;
    end
    check({tag, ".count"},     64'(count),           64'(model_q.size()));
    check({tag, ".in_ready"},  64'(in_ready),        64'(model_q.size() < DEPTH));
    check({tag, ".out_valid"}, 64'(out_valid),       64'(model_q.size() != 0));
    check({tag, ".out_ins"},   64'(out_instruction), 64'(exp_ins));
    check({tag, ".out_npc"},   64'(out_npc),         64'(exp_npc));
  endtask

  // One clock: drive at negedge, check before the edge, advance the model at the edge.
  task automatic cycle(input string tag, input logic iv, input logic [31:0] ins,
                       input logic [31:0] npc, input logic ordy, input logic fl);
    bit    do_push;
    bit    do_pop;
    pair_t p;
    in_valid       = iv;
    in_instruction = ins;
    in_npc         = npc;
    out_ready      = ordy;
    flush          = fl;
    #1;
    check_outputs(tag);
    do_push = iv && (model_q.size() < DEPTH);
    do_pop  = ordy && (model_q.size() != 0);
    p.ins   = ins;
    p.npc   = npc;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(p);
    end
    @(negedge clk);
  endtask

  initial begin
    int pushes;
    int pops;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_instruction = '0;
    in_npc = '0;
    #2;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill then attempt an overflow push, then drain in order.
    for (int i = 0; i < DEPTH; i++)
      cycle("fill", 1'b1, 32'h20080001 + 32'(i), 32'(4 * (i + 1)), 1'b0, 1'b0);
    cycle("overflow", 1'b1, 32'hDEADBEEF, 32'h14, 1'b0, 1'b0);
    check("full.count", 64'(count), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++)
      cycle("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check_outputs("drained");

    // Reset asserted mid-cycle with three entries queued.
    for (int i = 0; i < 3; i++)
      cycle("prerst", 1'b1, $urandom, $urandom, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    model_q.delete();
    #1;
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // Streaming: count holds at one, each pair visible the cycle after its push.
    for (int i = 0; i < 8; i++)
      cycle("stream", 1'b1, $urandom, $urandom, 1'b1, 1'b0);
    cycle("stream_end", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Full with simultaneous pop: pop taken, push refused, then accepted.
    for (int i = 0; i < DEPTH; i++)
      cycle("fill2", 1'b1, $urandom, $urandom, 1'b0, 1'b0);
    cycle("full_pop", 1'b1, 32'h11112222, 32'h33334444, 1'b1, 1'b0);
    check("full_pop.count", 64'(count), 64'(DEPTH - 1));
    cycle("refill", 1'b1, 32'h11112222, 32'h33334444, 1'b0, 1'b0);
    check("refill.count", 64'(count), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++)
      cycle("drain2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with concurrent push and pop, then consecutive flushes.
    for (int i = 0; i < 3; i++)
      cycle("preflush", 1'b1, $urandom, $urandom, 1'b0, 1'b0);
    cycle("flush", 1'b1, 32'hBADBAD00, 32'h40, 1'b1, 1'b1);
    cycle("post_flush", 1'b1, 32'h8C010000, 32'h44, 1'b0, 1'b0);
    check("flush.head", 64'(out_instruction), 64'h8C010000);
    cycle("flush2a", 1'b1, $urandom, $urandom, 1'b0, 1'b1);
    cycle("flush2b", 1'b1, $urandom, $urandom, 1'b1, 1'b1);
    cycle("flush_idle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Wrap-around: ten pushes and ten pops in random interleaving.
    pushes = 0;
    pops = 0;
    while (pops < 10) begin
      bit iv;
      bit ordy;
      iv   = (pushes < 10) && ($urandom_range(0, 1) == 1);
      ordy = $urandom_range(0, 1) == 1;
      if (iv && model_q.size() < DEPTH) pushes++;
      if (ordy && model_q.size() != 0) pops++;
      cycle("wrap", iv, $urandom, $urandom, ordy, 1'b0);
      check("wrap.max", 64'(count <= CNT_W'(DEPTH)), 64'd1);
    end

    // Random soak including occasional flushes.
    for (int i = 0; i < 300; i++)
      cycle("soak", $urandom_range(0, 3) != 0, $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    check_outputs("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised IF/ID decoupling queue placed between the instruction fetch stage and the decode stage. It replaces the single-entry IF/ID latch with a DEPTH-entry first-in-first-out buffer of {instruction, npc} pairs. It uses valid/ready handshakes on both sides and a synchronous flush for branch/jump redirects. Fetch keeps running while decode stalls, until the queue fills.

## Interface
- DATA_W, 32, instruction width in bits
- NPC_W, 32, next-PC width in bits
- DEPTH, 4, number of entries; power of two, minimum 2
- CNT_W, $clog2(DEPTH+1), width of the occupancy count
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  discards all queued entries; sampled on the rising edge
- in_valid  input  1  fetch presents a valid pair
- in_ready  output  1  queue can accept a pair
- in_instruction  input  DATA_W  instruction from fetch
- in_npc  input  NPC_W  next PC from fetch
- out_valid  output  1  head entry is valid for decode
- out_ready  input  1  decode consumes the head entry
- out_instruction  output  DATA_W  head instruction
- out_npc  output  NPC_W  head next PC
- count  output  CNT_W  current occupancy, 0..DEPTH

## Operation
- Storage is a circular buffer of DEPTH entries, with a write pointer and a read pointer, each $clog2(DEPTH) bits wide.
- Both pointers wrap naturally modulo DEPTH.
- A push occurs when in_valid && in_ready. The entry is written at the write pointer, and the write pointer increments.
- A pop occurs when out_valid && out_ready. The read pointer increments.
- in_ready = (count != DEPTH).
  - It is decoded from registered state only, with no combinational path from out_ready.
  - A push into a full queue is therefore never accepted, even if a pop occurs in the same cycle.
- out_valid = (count != 0), decoded from registered state only.
- When out_valid = 1, out_instruction and out_npc show the entry at the read pointer (first-word fall-through from storage).
- When out_valid = 0, out_instruction and out_npc are forced to all-zeros, so decode sees a NOP bubble.
- count update per cycle:
  - push only: count + 1
  - pop only: count − 1
  - push and pop together: unchanged
  - neither: unchanged
- Flush has priority over everything else:
  - count, the write pointer and the read pointer all go to 0.
  - Any same-cycle push and pop are ignored, and nothing is written.
  - Storage contents are not cleared.
- in_valid while in_ready = 0 is legal. The pair is held off and not stored; fetch must hold it.
- out_ready while out_valid = 0 is legal and has no effect.
- There is no state machine beyond the count and pointers. The full/empty condition is derived from count alone, so no pointer-equality ambiguity arises.

## Timing
- Reset (rst = 1, asynchronous): count = 0, both pointers = 0, in_ready = 1, out_valid = 0, out_instruction = 0, out_npc = 0.
- Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- Reset release is synchronous to clk by the system. The first push can occur on the first rising edge after rst falls.
- Latency:
  - A pair pushed on edge N appears at the outputs with out_valid = 1 after edge N, and can be popped on edge N+1.
  - There is no same-cycle bypass: minimum latency is 1 cycle.
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- Full boundary: at count = DEPTH, in_ready = 0. A pop on edge N gives count = DEPTH−1 and in_ready = 1 after edge N.
- Empty boundary: at count = 0, out_valid = 0. A push on edge N gives out_valid = 1 after edge N.
- Flush timing:
  - flush sampled high on edge N gives count = 0, out_valid = 0 and in_ready = 1 after edge N.
  - A push on edge N+1 is accepted normally.
- Flush asserted on consecutive cycles keeps the queue empty.

## Test plan
- **Reset:** assert rst mid-cycle with 3 entries queued → count = 0, out_valid = 0, in_ready = 1, out_instruction = 32'h0 immediately, without a clock edge.
- **Fill and drain:** DEPTH = 4, out_ready = 0, push 0x20080001..0x20080004 with npc 0x4..0x10.
  - After 4 edges: count = 4, in_ready = 0.
  - A fifth push of 0xDEADBEEF is not accepted.
  - Raise out_ready: pairs emerge in order over 4 cycles, then out_valid = 0 and outputs are 0.
- **Streaming:** in_valid = out_ready = 1 continuously, with a new pair each cycle → count holds at 1. Each pair appears exactly 1 cycle after its push, with no gaps.
- **Full with simultaneous pop:** count = 4, in_valid = 1, out_ready = 1 → the pop is taken, the push is refused (in_ready = 0 that cycle), count = 3. The push is accepted the next cycle, giving count = 4.
- **Flush:** count = 3, assert flush together with in_valid and out_ready for one edge → count = 0, out_valid = 0.
  - The pushed pair never appears.
  - The next push of 0x8C010000 is the next pair seen at the output.
- **Wrap-around:** with DEPTH = 4, perform 10 push/pop pairs in random interleaving → output order matches input order across pointer wrap, and count never exceeds 4.
